hub75_scan_driver: RTL and testbench

HUB75_SCAN_DRIVER -- requirements
Module: hub75_scan_driver

---
 rtl/hub75_pkg.sv | 46 ++++
 rtl/hub75_bcm_timer.sv | 38 +++
 rtl/hub75_scan_driver.sv | 181 ++++++++++++++++++
 tb/tb_hub75_scan_driver.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/hub75_pkg.sv
// Shared definitions for the HUB75 scan driver: FSM states, panel geometry,
// colour byte layout of a frame-buffer word and the bit-plane extraction helper.
package hub75_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SHIFT   = 3'd1,
        ST_BLANK   = 3'd2,
        ST_LATCH   = 3'd3,
        ST_DISPLAY = 3'd4
    } state_t;

    localparam int unsigned COLS   = 32;
    localparam int unsigned ROWS   = 16;
    localparam int unsigned PLANES = 8;

    localparam logic [4:0] COL_LAST   = 5'(COLS - 1);
    localparam logic [3:0] ROW_LAST   = 4'(ROWS - 1);
    localparam logic [2:0] PLANE_LAST = 3'(PLANES - 1);

    localparam int unsigned RED1_OFS   = 0;
    localparam int unsigned GREEN1_OFS = 8;
    localparam int unsigned BLUE1_OFS  = 16;
    localparam int unsigned RED2_OFS   = 24;
    localparam int unsigned GREEN2_OFS = 32;
    localparam int unsigned BLUE2_OFS  = 40;

    // Returns {b2, g2, r2, b1, g1, r1} for the selected bit plane.
    function automatic logic [5:0] plane_bits(input logic [47:0] data, input logic [2:0] plane);
        logic [7:0] r1_byte;
        logic [7:0] g1_byte;
        logic [7:0] b1_byte;
        logic [7:0] r2_byte;
        logic [7:0] g2_byte;
        logic [7:0] b2_byte;
        r1_byte = data[RED1_OFS +: 8];
        g1_byte = data[GREEN1_OFS +: 8];
        b1_byte = data[BLUE1_OFS +: 8];
        r2_byte = data[RED2_OFS +: 8];
        g2_byte = data[GREEN2_OFS +: 8];
        b2_byte = data[BLUE2_OFS +: 8];
        return {b2_byte[plane], g2_byte[plane], r2_byte[plane],
                b1_byte[plane], g1_byte[plane], r1_byte[plane]};
    endfunction

endpackage

// File: rtl/hub75_bcm_timer.sv
// Display-time counter for binary-coded modulation: after start, done rises
// once BASE_TIME << plane cycles have elapsed (16 bits covers 255 << 7).
module hub75_bcm_timer #(
    parameter int unsigned BASE_TIME = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [2:0] plane,
    output logic       done
);

    logic [15:0] count_r;
    logic [15:0] load_s;

    // Remaining cycles minus one, so done lines up with the last display cycle.
    always_comb begin
        load_s = (16'(BASE_TIME) << plane) - 16'd1;
    end

    // Down-counter with a registered terminal flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_r <= 16'd0;
            done    <= 1'b0;
        end else if (start) begin
            count_r <= load_s;
            done    <= (load_s == 16'd0);
        end else if (count_r != 16'd0) begin
            count_r <= count_r - 16'd1;
            done    <= (count_r == 16'd1);
        end else begin
            count_r <= count_r;
            done    <= done;
        end
    end

endmodule

// File: rtl/hub75_scan_driver.sv
// HUB75 panel scan driver: shifts 32 columns per row pair, blanks, latches,
// then shows each of 8 bit planes for a binary-weighted time.
module hub75_scan_driver #(
    parameter int unsigned BASE_TIME = 8
) (
    input  logic        clk,
    input  logic        rst,
    output logic [8:0]  ram_address,
    input  logic [47:0] ram_data,
    output logic        r1,
    output logic        g1,
    output logic        b1,
    output logic        r2,
    output logic        g2,
    output logic        b2,
    output logic [3:0]  row_addr,
    output logic        pix_clk,
    output logic        lat,
    output logic        oe_n,
    output logic        frame_done
);
    import hub75_pkg::*;

    state_t      state_r;
    state_t      state_s;
    logic [1:0]  phase_r;
    logic [1:0]  phase_s;
    logic [4:0]  col_r;
    logic [4:0]  col_s;
    logic [3:0]  row_r;
    logic [3:0]  row_s;
    logic [2:0]  plane_r;
    logic [2:0]  plane_s;
    logic        frame_s;
    logic        timer_start_s;
    logic        timer_done_s;
    logic        in_sample_s;
    logic [5:0]  colour_r;
    logic [5:0]  colour_s;
    logic [5:0]  colour_nxt_s;
    logic [8:0]  ram_address_r;
    logic [8:0]  ram_address_s;
    logic [3:0]  row_addr_r;
    logic [3:0]  row_addr_s;
    logic        pix_clk_r;
    logic        pix_clk_s;
    logic        lat_r;
    logic        lat_s;
    logic        oe_n_r;
    logic        oe_n_s;
    logic        frame_done_r;

    assign timer_start_s = (state_r == ST_LATCH);

    hub75_bcm_timer #(
        .BASE_TIME (BASE_TIME)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .start (timer_start_s),
        .plane (plane_r),
        .done  (timer_done_s)
    );

    // Scan sequencing: next state, column phase, column, row and plane.
    always_comb begin
        state_s = state_r;
        phase_s = phase_r;
        col_s   = col_r;
        row_s   = row_r;
        plane_s = plane_r;
        frame_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                state_s = ST_SHIFT;
                phase_s = 2'd0;
                col_s   = 5'd0;
            end
            ST_SHIFT: begin
                phase_s = phase_r + 2'd1;
                if (phase_r == 2'd3) begin
                    if (col_r == COL_LAST) begin
                        state_s = ST_BLANK;
                        col_s   = 5'd0;
                    end else begin
                        col_s = col_r + 5'd1;
                    end
                end else begin
                    col_s = col_r;
                end
            end
            ST_BLANK: state_s = ST_LATCH;
            ST_LATCH: state_s = ST_DISPLAY;
            ST_DISPLAY: begin
                if (timer_done_s) begin
                    state_s = ST_SHIFT;
                    phase_s = 2'd0;
                    plane_s = plane_r + 3'd1;
                    if (plane_r == PLANE_LAST) begin
                        row_s   = row_r + 4'd1;
                        frame_s = (row_r == ROW_LAST);
                    end else begin
                        row_s = row_r;
                    end
                end else begin
                    state_s = ST_DISPLAY;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Panel signal values for the upcoming cycle; colour passes straight
    // through in phase 1 so only that cycle's ram_data is ever used.
    always_comb begin
        in_sample_s = (state_r == ST_SHIFT) && (phase_r == 2'd1);
        if (in_sample_s) begin
            colour_s = plane_bits(ram_data, plane_r);
        end else begin
            colour_s = colour_r;
        end
        if (state_s == ST_BLANK) begin
            colour_nxt_s = 6'd0;
        end else begin
            colour_nxt_s = colour_s;
        end
        if ((state_s == ST_SHIFT) && (phase_s == 2'd0)) begin
            ram_address_s = {row_s, col_s};
        end else begin
            ram_address_s = ram_address_r;
        end
        if (state_s == ST_LATCH) begin
            row_addr_s = row_r;
        end else begin
            row_addr_s = row_addr_r;
        end
        pix_clk_s = (state_s == ST_SHIFT) && phase_s[1];
        lat_s     = (state_s == ST_LATCH);
        oe_n_s    = (state_s != ST_DISPLAY);
    end

    // State and output registers; reset forces the panel dark and unlatched.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r       <= ST_IDLE;
            phase_r       <= 2'd0;
            col_r         <= 5'd0;
            row_r         <= 4'd0;
            plane_r       <= 3'd0;
            colour_r      <= 6'd0;
            ram_address_r <= 9'd0;
            row_addr_r    <= 4'd0;
            pix_clk_r     <= 1'b0;
            lat_r         <= 1'b0;
            oe_n_r        <= 1'b1;
            frame_done_r  <= 1'b0;
        end else begin
            state_r       <= state_s;
            phase_r       <= phase_s;
            col_r         <= col_s;
            row_r         <= row_s;
            plane_r       <= plane_s;
            colour_r      <= colour_nxt_s;
            ram_address_r <= ram_address_s;
            row_addr_r    <= row_addr_s;
            pix_clk_r     <= pix_clk_s;
            lat_r         <= lat_s;
            oe_n_r        <= oe_n_s;
            frame_done_r  <= frame_s;
        end
    end

    assign {b2, g2, r2, b1, g1, r1} = colour_s;
    assign ram_address = ram_address_r;
    assign row_addr    = row_addr_r;
    assign pix_clk     = pix_clk_r;
    assign lat         = lat_r;
    assign oe_n        = oe_n_r;
    assign frame_done  = frame_done_r;

endmodule

// File: tb/tb_hub75_scan_driver.sv
// Directed bench: instance A (BASE_TIME 8) covers reset, abort, timing and a
// full frame; instance B (BASE_TIME 255) covers the longest display plane.
module tb_hub75_scan_driver;

    // 16 rows * 8 planes * (128 shift + blank + latch) + 16 * 8 * (1+2+..+128)
    localparam int FRAME_LEN = 16 * (8 * 130 + 8 * 255);
    localparam logic [47:0] ROW1_DATA = 48'h80_40_20_04_02_81;

    logic        clk = 1'b0;
    logic        rst_a;
    logic        rst_b;
    logic [47:0] ram_data;

    logic [8:0]  addr_a, addr_b;
    logic        r1_a, g1_a, b1_a, r2_a, g2_a, b2_a;
    logic        r1_b, g1_b, b1_b, r2_b, g2_b, b2_b;
    logic [3:0]  row_a, row_b;
    logic        pix_a, pix_b, lat_a, lat_b, oe_n_a, oe_n_b, fd_a, fd_b;
    logic [22:0] vec_a, vec_b;
    logic [5:0]  col_a;

    int total_cnt = 0;
    int bad_cnt   = 0;
    bit b_done    = 1'b0;

    always #5 clk = ~clk;

    hub75_scan_driver #(.BASE_TIME(8)) dut_a (
        .clk(clk), .rst(rst_a), .ram_address(addr_a), .ram_data(ram_data),
        .r1(r1_a), .g1(g1_a), .b1(b1_a), .r2(r2_a), .g2(g2_a), .b2(b2_a),
        .row_addr(row_a), .pix_clk(pix_a), .lat(lat_a), .oe_n(oe_n_a), .frame_done(fd_a)
    );

    hub75_scan_driver #(.BASE_TIME(255)) dut_b (
        .clk(clk), .rst(rst_b), .ram_address(addr_b), .ram_data(ram_data),
        .r1(r1_b), .g1(g1_b), .b1(b1_b), .r2(r2_b), .g2(g2_b), .b2(b2_b),
        .row_addr(row_b), .pix_clk(pix_b), .lat(lat_b), .oe_n(oe_n_b), .frame_done(fd_b)
    );

    assign col_a = {b2_a, g2_a, r2_a, b1_a, g1_a, r1_a};
    assign vec_a = {addr_a, col_a, row_a, pix_a, lat_a, oe_n_a, fd_a};
    assign vec_b = {addr_b, b2_b, g2_b, r2_b, b1_b, g1_b, r1_b, row_b, pix_b, lat_b, oe_n_b, fd_b};

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        if (obs !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Instance B: widths of plane 0 and plane 7 of row 0.
    initial begin : b_mon
        int len;
        int runs;
        logic prev;
        len  = 0;
        runs = 0;
        prev = 1'b1;
        @(posedge rst_b);
        for (int i = 0; i < 70000 && !b_done; i++) begin
            @(negedge clk);
            if (!oe_n_b) len++;
            if (oe_n_b && !prev) begin
                if (runs == 0) check_val("b_oe_w_p0", len, 255);
                if (runs == 7) begin
                    check_val("b_oe_w_p7", len, 32640);
                    b_done = 1'b1;
                end
                runs++;
                len = 0;
            end
            prev = oe_n_b;
        end
    end

    initial begin : main
        int n, runs, cur_len, lat_cnt, rises, addr_err, lat_err, fd_cnt, fd_cyc;
        logic oe_prev, pix_prev;
        logic [8:0] held_addr, exp_addr;
        logic [5:0] c_or, c_and, exp_col;
        logic [5:0] row1_exp [8];
        bit reached;

        row1_exp = '{6'b000001, 6'b000010, 6'b000100, 6'b000000,
                     6'b000000, 6'b001000, 6'b010000, 6'b100001};
        rst_a    = 1'b0;
        rst_b    = 1'b0;
        ram_data = 48'h0000_0000_0001;
        repeat (3) @(negedge clk);
        check_val("rst_vec_a", 32'(vec_a), 32'h2);
        check_val("rst_vec_b", 32'(vec_b), 32'h2);
        rst_a = 1'b1;
        rst_b = 1'b1;

        // Run into plane 5 display, then pull reset mid-display.
        runs    = 0;
        cur_len = 0;
        oe_prev = 1'b1;
        reached = 1'b0;
        for (int i = 0; i < 3000 && !reached; i++) begin
            @(negedge clk);
            if (!oe_n_a && oe_prev) begin
                runs++;
                cur_len = 0;
            end
            if (!oe_n_a) cur_len++;
            oe_prev = oe_n_a;
            if (runs == 6 && cur_len == 10) reached = 1'b1;
        end
        check_val("p5_reached", 32'(reached), 32'd1);
        rst_a = 1'b0;
        #1;
        check_val("abort_vec", 32'(vec_a), 32'h2);
        repeat (3) @(negedge clk);
        check_val("abort_hold_vec", 32'(vec_a), 32'h2);
        rst_a = 1'b1;

        // One full frame plus a little of the next.
        n = 0; runs = 0; cur_len = 0; lat_cnt = 0; rises = 0;
        addr_err = 0; lat_err = 0; fd_cnt = 0; fd_cyc = 0;
        oe_prev = 1'b1; pix_prev = 1'b0; held_addr = 9'd0;
        c_or = 6'd0; c_and = 6'h3F;
        for (int i = 0; i < FRAME_LEN + 20; i++) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                check_val("first_addr", 32'(addr_a), 32'd0);
                check_val("first_pix", 32'(pix_a), 32'd0);
            end
            if (lat_a) begin
                lat_cnt++;
                if (lat_cnt == 1) begin
                    check_val("first_lat_cyc", n, 130);
                    check_val("first_lat_row", 32'(row_a), 32'd0);
                    check_val("lat_oe_n", 32'(oe_n_a), 32'd1);
                end
                if (n <= FRAME_LEN && int'(row_a) != (lat_cnt - 1) / 8) lat_err++;
            end
            if (pix_a && !pix_prev && n <= FRAME_LEN) begin
                exp_addr = {4'(rises / 256), 5'(rises % 32)};
                if (addr_a !== exp_addr) addr_err++;
                held_addr = addr_a;
                rises++;
            end else if (pix_a && n <= FRAME_LEN && addr_a !== held_addr) begin
                addr_err++;
            end
            if (pix_a) begin
                c_or  = c_or | col_a;
                c_and = c_and & col_a;
            end
            if (!oe_n_a) cur_len++;
            if (oe_n_a && !oe_prev) begin
                if (runs < 16) begin
                    if (runs < 8) check_val($sformatf("oe_w_p%0d", runs), cur_len, 8 << runs);
                    exp_col = (runs < 8) ? ((runs == 0) ? 6'b000001 : 6'b000000) : row1_exp[runs - 8];
                    check_val($sformatf("colour_r%0d_p%0d", runs / 8, runs % 8),
                              32'({c_or, c_and}), 32'({exp_col, exp_col}));
                end
                runs++;
                cur_len = 0;
                c_or    = 6'd0;
                c_and   = 6'h3F;
                if (runs == 8)  ram_data = ROW1_DATA;
                if (runs == 16) ram_data = 48'd0;
            end
            if (fd_a) begin
                fd_cnt++;
                if (fd_cnt == 1) fd_cyc = n;
                if (n == FRAME_LEN + 1) check_val("wrap_addr", 32'(addr_a), 32'd0);
            end
            oe_prev  = oe_n_a;
            pix_prev = pix_a;
        end
        check_val("addr_rises", rises, 4096);
        check_val("addr_seq_err", addr_err, 0);
        check_val("lat_count", lat_cnt, 128);
        check_val("lat_row_err", lat_err, 0);
        check_val("frame_done_count", fd_cnt, 1);
        check_val("frame_done_cyc", fd_cyc, FRAME_LEN + 1);

        for (int i = 0; i < 30000 && !b_done; i++) @(negedge clk);
        check_val("b_plane7_seen", 32'(b_done), 32'd1);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
